// File: rtl/sitcpxg_rx_buffer_reader.sv
// SiTCP-XG user TCP receive buffer: stores core writes, streams them out in order as left-justified
// 64-bit beats with valid/ready, and returns the consumed pointer. Optional stats: SITCPXG_RXBUF_STAT_EN.
module sitcpxg_rx_buffer_reader #(
    parameter int BUF_AW = 12
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTn,
    input  logic [15:0] USER_RX_WADR,
    input  logic [7:0]  USER_RX_WENB,
    input  logic [63:0] USER_RX_WDAT,
    output logic [15:0] USER_RX_RADR,
    output logic [15:0] USER_RX_SIZE,
    input  logic        USER_RX_CLR_ENB,
    output logic        USER_RX_CLR_REQ,
    output logic [63:0] OUT_D,
    output logic [3:0]  OUT_B,
    output logic        OUT_VALID,
`ifdef SITCPXG_RXBUF_STAT_EN
    output logic [31:0] STAT_RX_BYTES,
    output logic        STAT_FIFO_FULL,
`endif
    input  logic        OUT_READY
);
    localparam int PW    = BUF_AW + 3;
    localparam int WORDS = 1 << BUF_AW;

    typedef enum logic [1:0] {CLR_IDLE = 2'd0, CLR_PEND = 2'd1, CLR_PULSE = 2'd2} clr_state_t;

    // End offset within the word: the lowest set enable bit marks the last byte written.
    function automatic logic [3:0] wenb_end(input logic [7:0] enb);
        logic [3:0] e;
        e = 4'd0;
        for (int b = 7; b >= 0; b--) begin
            if (enb[b]) begin
                e = 4'(8 - b);
            end
        end
        return e;
    endfunction

    logic [63:0]       ram_r [WORDS];
    logic [PW-1:0]     wptr_r, iptr_r, rptr_r;
    logic              s0_valid_r, s1_valid_r;
    logic [BUF_AW-1:0] s0_word_r;
    logic [2:0]        s0_off_r, s1_off_r;
    logic [3:0]        s0_n_r, s1_n_r;
    logic [63:0]       rd_data_r;
    logic [63:0]       fifo_d_r [4];
    logic [3:0]        fifo_b_r [4];
    logic [1:0]        fifo_wr_r, fifo_rd_r;
    logic [2:0]        fifo_cnt_r;
    logic              out_valid_r, clr_req_r;
    logic [63:0]       out_d_r;
    logic [3:0]        out_b_r;
    clr_state_t        clr_state_r;

    logic [PW-1:0]     avail_s, wr_end_s;
    logic [3:0]        room_s, n_s, head_b_s;
    logic [2:0]        inflight_s, cnt_next_s;
    logic              issue_s, push_s, pop_s, drained_s;
    logic [1:0]        rd_next_s;
    logic [63:0]       push_d_s, head_d_s;
    logic              wadr_unused_s;

    if (PW < 16) begin : g_wadr_hi
        assign wadr_unused_s = ^{USER_RX_WADR[15:PW], USER_RX_WADR[2:0]};
    end else begin : g_wadr_full
        assign wadr_unused_s = ^USER_RX_WADR[2:0];
    end

    // Issue decision, lane alignment of the read word and FIFO head look-ahead.
    always_comb begin
        avail_s    = wptr_r - iptr_r;
        room_s     = 4'd8 - {1'b0, iptr_r[2:0]};
        if (avail_s < PW'(room_s)) begin
            n_s = avail_s[3:0];
        end else begin
            n_s = room_s;
        end
        inflight_s = fifo_cnt_r + {2'b00, s0_valid_r} + {2'b00, s1_valid_r};
        issue_s    = (avail_s != {PW{1'b0}}) && (inflight_s < 3'd4) && (clr_state_r != CLR_PULSE);
        push_s     = s1_valid_r;
        push_d_s   = (rd_data_r << {s1_off_r, 3'b000}) &
                     ~(64'hFFFF_FFFF_FFFF_FFFF >> {s1_n_r, 3'b000});
        pop_s      = out_valid_r & OUT_READY;
        rd_next_s  = fifo_rd_r + {1'b0, pop_s};
        cnt_next_s = fifo_cnt_r + {2'b00, push_s} - {2'b00, pop_s};
        // Occupancy never exceeds four, so a push landing on the next head means the FIFO was empty.
        if (push_s && (fifo_wr_r == rd_next_s)) begin
            head_d_s = push_d_s;
            head_b_s = s1_n_r;
        end else begin
            head_d_s = fifo_d_r[rd_next_s];
            head_b_s = fifo_b_r[rd_next_s];
        end
        drained_s  = (avail_s == {PW{1'b0}}) && !s0_valid_r && !s1_valid_r && (fifo_cnt_r == 3'd0);
        wr_end_s   = {USER_RX_WADR[PW-1:3], 3'b000} + PW'(wenb_end(USER_RX_WENB));
    end

    // Byte-enabled buffer RAM write port.
    always_ff @(posedge XGMII_CLOCK) begin
        for (int b = 0; b < 8; b++) begin
            if (USER_RX_WENB[7 - b]) begin
                ram_r[USER_RX_WADR[PW-1:3]][63 - 8*b -: 8] <= USER_RX_WDAT[63 - 8*b -: 8];
            end
        end
    end

    // Registered RAM read for the beat sitting in S0.
    always_ff @(posedge XGMII_CLOCK) begin
        rd_data_r <= ram_r[s0_word_r];
    end

    // Write, issue and consumed pointers; a clear pulse overrides every update.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            wptr_r <= {PW{1'b0}};
            iptr_r <= {PW{1'b0}};
            rptr_r <= {PW{1'b0}};
        end else if (clr_state_r == CLR_PULSE) begin
            wptr_r <= {PW{1'b0}};
            iptr_r <= {PW{1'b0}};
            rptr_r <= {PW{1'b0}};
        end else begin
            if (USER_RX_WENB != 8'h00) begin
                wptr_r <= wr_end_s;
            end
            if (issue_s) begin
                iptr_r <= iptr_r + PW'(n_s);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(out_b_r);
            end
        end
    end

    // S0/S1 beat descriptors travelling alongside the RAM read.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            s0_valid_r <= 1'b0;
            s0_word_r  <= {BUF_AW{1'b0}};
            s0_off_r   <= 3'd0;
            s0_n_r     <= 4'd0;
            s1_valid_r <= 1'b0;
            s1_off_r   <= 3'd0;
            s1_n_r     <= 4'd0;
        end else begin
            s0_valid_r <= issue_s;
            s0_word_r  <= iptr_r[PW-1:3];
            s0_off_r   <= iptr_r[2:0];
            s0_n_r     <= n_s;
            s1_valid_r <= s0_valid_r;
            s1_off_r   <= s0_off_r;
            s1_n_r     <= s0_n_r;
        end
    end

    // Four-entry output FIFO with registered head presented on OUT_*.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 4; i++) begin
                fifo_d_r[i] <= 64'd0;
                fifo_b_r[i] <= 4'd0;
            end
            fifo_wr_r   <= 2'd0;
            fifo_rd_r   <= 2'd0;
            fifo_cnt_r  <= 3'd0;
            out_valid_r <= 1'b0;
            out_d_r     <= 64'd0;
            out_b_r     <= 4'd0;
        end else begin
            if (push_s) begin
                fifo_d_r[fifo_wr_r] <= push_d_s;
                fifo_b_r[fifo_wr_r] <= s1_n_r;
                fifo_wr_r           <= fifo_wr_r + 2'd1;
            end
            fifo_rd_r   <= rd_next_s;
            fifo_cnt_r  <= cnt_next_s;
            out_valid_r <= (cnt_next_s != 3'd0);
            out_d_r     <= (cnt_next_s != 3'd0) ? head_d_s : 64'd0;
            out_b_r     <= (cnt_next_s != 3'd0) ? head_b_s : 4'd0;
        end
    end

    // Buffer clear handshake with the core.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            clr_state_r <= CLR_IDLE;
            clr_req_r   <= 1'b0;
        end else begin
            case (clr_state_r)
                CLR_IDLE: begin
                    clr_req_r   <= 1'b0;
                    clr_state_r <= USER_RX_CLR_ENB ? CLR_PEND : CLR_IDLE;
                end
                CLR_PEND: begin
                    if (!USER_RX_CLR_ENB) begin
                        clr_req_r   <= 1'b0;
                        clr_state_r <= CLR_IDLE;
                    end else if (drained_s) begin
                        clr_req_r   <= 1'b1;
                        clr_state_r <= CLR_PULSE;
                    end else begin
                        clr_req_r   <= 1'b0;
                        clr_state_r <= CLR_PEND;
                    end
                end
                CLR_PULSE: begin
                    clr_req_r   <= 1'b0;
                    clr_state_r <= CLR_IDLE;
                end
                default: begin
                    clr_req_r   <= 1'b0;
                    clr_state_r <= CLR_IDLE;
                end
            endcase
        end
    end

`ifdef SITCPXG_RXBUF_STAT_EN
    logic [31:0] stat_bytes_r;
    logic        stat_full_r;

    // Delivered-byte counter (survives buffer clears) and FIFO-full flag.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            stat_bytes_r <= 32'd0;
            stat_full_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                stat_bytes_r <= stat_bytes_r + {28'd0, out_b_r};
            end
            stat_full_r <= (cnt_next_s == 3'd4);
        end
    end

    assign STAT_RX_BYTES  = stat_bytes_r;
    assign STAT_FIFO_FULL = stat_full_r;
`endif

    assign USER_RX_RADR    = 16'(rptr_r);
    assign USER_RX_SIZE    = 16'((1 << PW) - 16);
    assign USER_RX_CLR_REQ = clr_req_r;
    assign OUT_D           = out_d_r;
    assign OUT_B           = out_b_r;
    assign OUT_VALID       = out_valid_r;

    sitcpxg_rx_buffer_reader_chk u_chk (
        .clk     (XGMII_CLOCK),
        .rst_n   (RSTn),
        .clr_enb (USER_RX_CLR_ENB),
        .wenb    (USER_RX_WENB)
    );
endmodule

// Protocol checker: the core must not write while it permits a buffer clear.
module sitcpxg_rx_buffer_reader_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       clr_enb,
    input logic [7:0] wenb
);
    a_no_write_during_clr: assert property (@(posedge clk) disable iff (!rst_n)
        !(clr_enb && (wenb != 8'h00)))
        else $error("rx buffer written while USER_RX_CLR_ENB is high");
endmodule

// File: tb/tb_sitcpxg_rx_buffer_reader.sv
// Scoreboard bench for sitcpxg_rx_buffer_reader (BUF_AW=9): directed streams, backpressure, wrap, clear, reset.
module tb_sitcpxg_rx_buffer_reader;
    logic        XGMII_CLOCK = 1'b0;
    logic        RSTn = 1'b1;
    logic [15:0] USER_RX_WADR = 16'd0;
    logic [7:0]  USER_RX_WENB = 8'h00;
    logic [63:0] USER_RX_WDAT = 64'd0;
    logic [15:0] USER_RX_RADR;
    logic [15:0] USER_RX_SIZE;
    logic        USER_RX_CLR_ENB = 1'b0;
    logic        USER_RX_CLR_REQ;
    logic [63:0] OUT_D;
    logic [3:0]  OUT_B;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
`ifdef SITCPXG_RXBUF_STAT_EN
    logic [31:0] STAT_RX_BYTES;
    logic        STAT_FIFO_FULL;
`endif

    sitcpxg_rx_buffer_reader #(.BUF_AW(9)) dut (
        .XGMII_CLOCK     (XGMII_CLOCK),
        .RSTn            (RSTn),
        .USER_RX_WADR    (USER_RX_WADR),
        .USER_RX_WENB    (USER_RX_WENB),
        .USER_RX_WDAT    (USER_RX_WDAT),
        .USER_RX_RADR    (USER_RX_RADR),
        .USER_RX_SIZE    (USER_RX_SIZE),
        .USER_RX_CLR_ENB (USER_RX_CLR_ENB),
        .USER_RX_CLR_REQ (USER_RX_CLR_REQ),
        .OUT_D           (OUT_D),
        .OUT_B           (OUT_B),
        .OUT_VALID       (OUT_VALID),
`ifdef SITCPXG_RXBUF_STAT_EN
        .STAT_RX_BYTES   (STAT_RX_BYTES),
        .STAT_FIFO_FULL  (STAT_FIFO_FULL),
`endif
        .OUT_READY       (OUT_READY)
    );

    always #5 XGMII_CLOCK = ~XGMII_CLOCK;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  b;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    int          n_req = 0;
    logic        hold_v = 1'b0;
    logic [63:0] hold_d = 64'd0;
    logic [3:0]  hold_b = 4'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [63:0] d, input logic [3:0] b);
        beat_t e;
        e.d = d;
        e.b = b;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] seq_word(input int base);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) begin
            w[63 - 8*b -: 8] = 8'((base + b) % 256);
        end
        return w;
    endfunction

    task automatic wr(input logic [15:0] a, input logic [7:0] e, input logic [63:0] d);
        USER_RX_WADR = a;
        USER_RX_WENB = e;
        USER_RX_WDAT = d;
        @(posedge XGMII_CLOCK);
        #1;
        USER_RX_WENB = 8'h00;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        USER_RX_WENB = 8'h00;
        USER_RX_CLR_ENB = 1'b0;
        OUT_READY = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge XGMII_CLOCK);
        #1;
        RSTn = 1'b1;
        @(posedge XGMII_CLOCK);
        #1;
    endtask

    task automatic wait_radr(input logic [15:0] v, input int budget, input string name);
        int k;
        k = 0;
        while ((USER_RX_RADR !== v) && (k < budget)) begin
            @(posedge XGMII_CLOCK);
            #1;
            k++;
        end
        check(name, 64'(USER_RX_RADR), 64'(v));
    endtask

    // Monitor: pops the scoreboard on each transfer and checks hold-stability under stall.
    always @(negedge XGMII_CLOCK) begin
        beat_t e;
        if (RSTn) begin
            if (USER_RX_CLR_REQ) n_req++;
            if (hold_v) begin
                check("stall_valid", 64'(OUT_VALID), 64'd1);
                check("stall_d", OUT_D, hold_d);
                check("stall_b", 64'(OUT_B), 64'(hold_b));
            end
            hold_v = OUT_VALID && !OUT_READY;
            hold_d = OUT_D;
            hold_b = OUT_B;
            if (OUT_VALID && OUT_READY) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got d=%h b=%0d, expected no beat", OUT_D, OUT_B);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_d", OUT_D, e.d);
                    check("beat_b", 64'(OUT_B), 64'(e.b));
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xfer_before;
        int k;
        // Reset state
        #1 RSTn = 1'b0;
        #2;
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_d", OUT_D, 64'd0);
        check("rst_b", 64'(OUT_B), 64'd0);
        check("rst_radr", 64'(USER_RX_RADR), 64'd0);
        check("rst_clr_req", 64'(USER_RX_CLR_REQ), 64'd0);
        check("size", 64'(USER_RX_SIZE), 64'd4080);
        do_reset();

        // Aligned stream: latency E3, one beat per cycle
        for (int i = 0; i < 4; i++) begin
            expect_beat(seq_word(8*i), 4'd8);
            wr(16'(8*i), 8'hFF, seq_word(8*i));
            if (i == 2) check("lat_after_e2", 64'(OUT_VALID), 64'd0);
            if (i == 3) check("lat_after_e3", 64'(OUT_VALID), 64'd1);
        end
        repeat (4) @(posedge XGMII_CLOCK);
        #1;
        check("aligned_radr_e7", 64'(USER_RX_RADR), 64'd32);
        check("aligned_sb_empty", 64'(exp_q.size()), 64'd0);

        // Partial / unaligned writes
        do_reset();
        expect_beat(64'hA1A2_A300_0000_0000, 4'd3);
        wr(16'd0, 8'hE0, 64'hA1A2_A3A4_A5A6_A7A8);
        wait_radr(16'd3, 20, "partial_radr3");
        expect_beat(64'hA4A5_A6A7_A800_0000, 4'd5);
        wr(16'd0, 8'h1F, 64'hA1A2_A3A4_A5A6_A7A8);
        wait_radr(16'd8, 20, "partial_radr8");
        check("partial_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: READY high one cycle in three
        do_reset();
        OUT_READY = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    expect_beat(seq_word(8*i), 4'd8);
                    wr(16'(8*i), 8'hFF, seq_word(8*i));
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge XGMII_CLOCK);
                    #1;
                    OUT_READY = (c % 3 == 0);
                end
            end
        join
        OUT_READY = 1'b1;
        wait_radr(16'd80, 100, "bp_radr");
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Pointer wrap: 10000 bytes through a 4096-byte buffer
        do_reset();
        for (int i = 0; i < 1250; i++) begin
            expect_beat(seq_word(8*i), 4'd8);
            wr(16'(8*i), 8'hFF, seq_word(8*i));
        end
        wait_radr(16'd1808, 50, "wrap_radr");
        check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);
        check("wrap_size", 64'(USER_RX_SIZE), 64'd4080);

        // Buffer clear
        do_reset();
        OUT_READY = 1'b0;
        expect_beat(64'h1111_2222_3333_4444, 4'd8);
        wr(16'd0, 8'hFF, 64'h1111_2222_3333_4444);
        expect_beat(64'h5555_6666_7777_8888, 4'd8);
        wr(16'd8, 8'hFF, 64'h5555_6666_7777_8888);
        USER_RX_CLR_ENB = 1'b1;
        n_req = 0;
        repeat (10) @(posedge XGMII_CLOCK);
        #1;
        check("clr_no_req_pending", 64'(n_req), 64'd0);
        OUT_READY = 1'b1;
        k = 0;
        while (k < 30) begin
            @(negedge XGMII_CLOCK);
            if (USER_RX_CLR_REQ) break;
            k++;
        end
        check("clr_req_seen", 64'(USER_RX_CLR_REQ), 64'd1);
        check("clr_radr_at_pulse", 64'(USER_RX_RADR), 64'd16);
        check("clr_sb_empty", 64'(exp_q.size()), 64'd0);
        USER_RX_CLR_ENB = 1'b0;
        @(negedge XGMII_CLOCK);
        check("clr_req_one_cycle", 64'(USER_RX_CLR_REQ), 64'd0);
        check("clr_radr_zero", 64'(USER_RX_RADR), 64'd0);
        @(posedge XGMII_CLOCK);
        #1;
        expect_beat(64'hCAFE_F00D_1234_5678, 4'd8);
        wr(16'd0, 8'hFF, 64'hCAFE_F00D_1234_5678);
        wait_radr(16'd8, 20, "clr_post_write_radr");
        check("clr_req_count", 64'(n_req), 64'd1);
        check("clr_post_sb_empty", 64'(exp_q.size()), 64'd0);

        // Async reset mid-stream
        do_reset();
        for (int i = 0; i < 2; i++) begin
            expect_beat(seq_word(8*i), 4'd8);
            wr(16'(8*i), 8'hFF, seq_word(8*i));
        end
        wait_radr(16'd16, 20, "arst_pre_radr");
        OUT_READY = 1'b0;
        for (int i = 2; i < 6; i++) begin
            expect_beat(seq_word(8*i), 4'd8);
            wr(16'(8*i), 8'hFF, seq_word(8*i));
        end
        repeat (6) @(posedge XGMII_CLOCK);
        #1;
        check("arst_pre_valid", 64'(OUT_VALID), 64'd1);
        #2;
        RSTn = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", 64'(OUT_VALID), 64'd0);
        check("arst_radr", 64'(USER_RX_RADR), 64'd0);
        check("arst_b", 64'(OUT_B), 64'd0);
        repeat (2) @(posedge XGMII_CLOCK);
        #3;
        RSTn = 1'b1;
        OUT_READY = 1'b1;
        xfer_before = n_xfer;
        repeat (20) @(posedge XGMII_CLOCK);
        #1;
        check("arst_no_beat", 64'(n_xfer - xfer_before), 64'd0);
        check("arst_valid_idle", 64'(OUT_VALID), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
